// File: rtl/fpga_pad_ring.sv
// Board IO ring: per-pad synchroniser, glitch filter, registered tristate drive and PLL-lock reset sequencer.
// Define FPGA_PAD_RING_LOOPBACK_EN to add loopback_i (core_out_i looped back to core_in_o, pads released).
module fpga_pad_ring #(
    parameter int NUM_PADS    = 8,
    parameter int FILT_CYCLES = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pll_locked_i,
`ifdef FPGA_PAD_RING_LOOPBACK_EN
    input  logic                loopback_i,
`endif
    output logic                rst_sys_no,
    input  logic [NUM_PADS-1:0] pad_in_i,
    output logic [NUM_PADS-1:0] pad_out_o,
    output logic [NUM_PADS-1:0] pad_oe_o,
    output logic [NUM_PADS-1:0] core_in_o,
    input  logic [NUM_PADS-1:0] core_out_i,
    input  logic [NUM_PADS-1:0] core_oe_i,
    input  logic [NUM_PADS-1:0] filt_en_i
);

    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]          r_state;
    logic [LW-1:0]       r_lock_cnt;
    logic                r_lock_m;
    logic                r_lock_s;
    logic [NUM_PADS-1:0] r_pad_m;
    logic [NUM_PADS-1:0] r_pad_s;
    logic [NUM_PADS-1:0] r_core_in;
    logic [NUM_PADS-1:0] r_pad_out;
    logic [NUM_PADS-1:0] r_pad_oe;
    logic [FW-1:0]       r_fc [NUM_PADS];
    logic [FW-1:0]       w_last [NUM_PADS];
    logic                w_run;
    logic                w_lb;

`ifdef FPGA_PAD_RING_LOOPBACK_EN
    assign w_lb = loopback_i;
`else
    assign w_lb = 1'b0;
`endif

    assign w_run      = (r_state == S_RUN);
    assign rst_sys_no = w_run;
    assign pad_out_o  = r_pad_out;
    assign pad_oe_o   = r_pad_oe;
    assign core_in_o  = r_core_in;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
            r_pad_m  <= '0;
            r_pad_s  <= '0;
        end else begin
            r_lock_m <= pll_locked_i;
            r_lock_s <= r_lock_m;
            r_pad_m  <= pad_in_i;
            r_pad_s  <= r_pad_m;
        end
    end

    // Lock must hold for LOCK_CYCLES consecutive cycles; any drop restarts the wait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_HOLD;
            r_lock_cnt <= '0;
        end else begin
            unique case (r_state)
                S_HOLD: r_state <= S_WAIT;
                S_WAIT: begin
                    if (r_lock_s) begin
                        r_state    <= S_COUNT;
                        r_lock_cnt <= '0;
                    end
                end
                S_COUNT: begin
                    if (!r_lock_s) begin
                        r_state <= S_WAIT;
                    end else if (r_lock_cnt == LOCK_LAST) begin
                        r_state <= S_RUN;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!r_lock_s) r_state <= S_WAIT;
                end
                default: r_state <= S_HOLD;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            w_last[i] = filt_en_i[i] ? FILT_LAST : '0;
        end
    end

    // >= so that lowering the threshold mid-count commits on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_core_in <= '0;
            for (int i = 0; i < NUM_PADS; i++) r_fc[i] <= '0;
        end else if (w_lb) begin
            r_core_in <= core_out_i;
            for (int i = 0; i < NUM_PADS; i++) r_fc[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                if (r_pad_s[i] == r_core_in[i]) begin
                    r_fc[i] <= '0;
                end else if (r_fc[i] >= w_last[i]) begin
                    r_core_in[i] <= r_pad_s[i];
                    r_fc[i]      <= '0;
                end else begin
                    r_fc[i] <= r_fc[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pad_out <= '0;
            r_pad_oe  <= '0;
        end else if (w_run && !w_lb) begin
            r_pad_out <= core_out_i;
            r_pad_oe  <= core_oe_i;
        end else begin
            r_pad_out <= '0;
            r_pad_oe  <= '0;
        end
    end

endmodule

// File: tb/tb_fpga_pad_ring.sv
// Directed bench for fpga_pad_ring: reset sequencing, lock glitches, filter, output gating, loopback.
module tb_fpga_pad_ring;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       pll_locked_i;
    logic       rst_sys_no;
    logic [7:0] pad_in_i;
    logic [7:0] pad_out_o;
    logic [7:0] pad_oe_o;
    logic [7:0] core_in_o;
    logic [7:0] core_out_i;
    logic [7:0] core_oe_i;
    logic [7:0] filt_en_i;
`ifdef FPGA_PAD_RING_LOOPBACK_EN
    logic       loopback_i;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    fpga_pad_ring #(
        .NUM_PADS(8),
        .FILT_CYCLES(4),
        .LOCK_CYCLES(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .pll_locked_i(pll_locked_i),
`ifdef FPGA_PAD_RING_LOOPBACK_EN
        .loopback_i(loopback_i),
`endif
        .rst_sys_no(rst_sys_no),
        .pad_in_i(pad_in_i),
        .pad_out_o(pad_out_o),
        .pad_oe_o(pad_oe_o),
        .core_in_o(core_in_o),
        .core_out_i(core_out_i),
        .core_oe_i(core_oe_i),
        .filt_en_i(filt_en_i)
    );

    // Advance one rising edge and settle; inputs written after this apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        pll_locked_i = 1'b1;
        pad_in_i     = '0;
        core_out_i   = '0;
        core_oe_i    = '0;
        filt_en_i    = 8'h01;
`ifdef FPGA_PAD_RING_LOOPBACK_EN
        loopback_i   = 1'b0;
`endif
        tick();
        tick();
        check("rst_sys_no_reset", {7'd0, rst_sys_no}, 8'h00);
        check("pad_oe_reset", pad_oe_o, 8'h00);
        check("pad_out_reset", pad_out_o, 8'h00);
        check("core_in_reset", core_in_o, 8'h00);

        // Release: HOLD(1), sync(2), COUNT entered edge 3, RUN at edge 19.
        rst_i     = 1'b0;
        core_oe_i = 8'hA5;
        for (int e = 1; e <= 18; e++) begin
            tick();
            check($sformatf("release_hold_e%0d", e), {7'd0, rst_sys_no}, 8'h00);
            check($sformatf("release_oe_e%0d", e), pad_oe_o, 8'h00);
        end
        tick();
        check("release_e19", {7'd0, rst_sys_no}, 8'h01);
        check("oe_first_run_edge", pad_oe_o, 8'h00);

        core_out_i = 8'h3C;
        tick();
        check("gate_oe", pad_oe_o, 8'hA5);
        check("gate_out", pad_out_o, 8'h3C);

        // Lock drop in RUN: 2 sync edges, state leaves RUN on edge 3, outputs on edge 4.
        pll_locked_i = 1'b0;
        tick();
        tick();
        check("drop_e2_still_run", {7'd0, rst_sys_no}, 8'h01);
        tick();
        check("drop_e3_rst", {7'd0, rst_sys_no}, 8'h00);
        check("drop_e3_oe", pad_oe_o, 8'hA5);
        tick();
        check("drop_e4_oe", pad_oe_o, 8'h00);
        check("drop_e4_out", pad_out_o, 8'h00);

        // COUNT at 3, glitch restarts at 15, boundary drop at 31, final COUNT at 32, RUN at 48.
        pll_locked_i = 1'b1;
        for (int e = 1; e <= 47; e++) begin
            tick();
            check($sformatf("glitch_hold_e%0d", e), {7'd0, rst_sys_no}, 8'h00);
            check($sformatf("glitch_oe_e%0d", e), pad_oe_o, 8'h00);
            if (e == 11 || e == 28) pll_locked_i = 1'b0;
            if (e == 12 || e == 29) pll_locked_i = 1'b1;
        end
        tick();
        check("glitch_release_e48", {7'd0, rst_sys_no}, 8'h01);
        check("glitch_oe_e48", pad_oe_o, 8'h00);
        tick();
        check("glitch_oe_e49", pad_oe_o, 8'hA5);

        // 3-cycle pulse on filtered ch0 is rejected.
        pad_in_i = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("filt_reject_e%0d", e), core_in_o, 8'h00);
            if (e == 3) pad_in_i = 8'h00;
        end

        // Stable high on ch0 lands on edge 6.
        pad_in_i = 8'h01;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("filt_accept_wait_e%0d", e), core_in_o, 8'h00);
        end
        tick();
        check("filt_accept_e6", core_in_o, 8'h01);

        // Unfiltered ch1: 3rd edge.
        pad_in_i = 8'h03;
        tick();
        tick();
        check("unfilt_e2", core_in_o, 8'h01);
        tick();
        check("unfilt_e3", core_in_o, 8'h03);
        pad_in_i = 8'h01;
        tick();
        tick();
        tick();
        check("unfilt_fall", core_in_o, 8'h01);

        // 1-cycle pulse on ch1 comes out as a 1-cycle pulse.
        pad_in_i = 8'h03;
        tick();
        pad_in_i = 8'h01;
        tick();
        check("pulse_e2", core_in_o, 8'h01);
        tick();
        check("pulse_e3", core_in_o, 8'h03);
        tick();
        check("pulse_e4", core_in_o, 8'h01);

        // ch2 filtered, threshold dropped at fc=2 commits on the next edge.
        filt_en_i = 8'h05;
        pad_in_i  = 8'h05;
        for (int e = 1; e <= 4; e++) tick();
        check("thresh_e4", core_in_o, 8'h01);
        filt_en_i = 8'h01;
        tick();
        check("thresh_e5", core_in_o, 8'h05);

`ifdef FPGA_PAD_RING_LOOPBACK_EN
        pad_in_i = 8'h00;
        for (int e = 1; e <= 8; e++) tick();
        check("lb_pre_core_in", core_in_o, 8'h00);
        core_out_i = 8'h5A;
        loopback_i = 1'b1;
        tick();
        check("lb_oe", pad_oe_o, 8'h00);
        check("lb_out", pad_out_o, 8'h00);
        check("lb_core_in", core_in_o, 8'h5A);
        filt_en_i  = 8'hFF;
        loopback_i = 1'b0;
        tick();
        tick();
        tick();
        check("lb_exit_e3", core_in_o, 8'h5A);
        tick();
        check("lb_exit_e4", core_in_o, 8'h00);
        check("lb_exit_oe", pad_oe_o, 8'hA5);
        check("lb_exit_out", pad_out_o, 8'h5A);
`endif

        // Reset mid-operation clears everything on the next edge.
        pad_in_i   = 8'hFF;
        filt_en_i  = 8'h00;
        for (int e = 1; e <= 4; e++) tick();
        check("pre_rst_core_in", core_in_o, 8'hFF);
        rst_i = 1'b1;
        tick();
        check("midrst_rst_sys", {7'd0, rst_sys_no}, 8'h00);
        check("midrst_oe", pad_oe_o, 8'h00);
        check("midrst_out", pad_out_o, 8'h00);
        check("midrst_core_in", core_in_o, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fpga_pad_ring.md
Name: fpga_pad_ring

Overview:
- Parametrised FPGA board-level IO ring and reset sequencer, sitting between board pins and the SoC top in each board wrapper.
- Generalises single-pin tristate muxing (e.g. UART TX) to NUM_PADS bidirectional channels.
- Per channel: input synchroniser, optional glitch filter and registered tristate output.
- Generates the active-low system reset from a synchronised PLL-lock qualifier.

Parameters:
- NUM_PADS, 8, number of bidirectional pad channels (>=1)
- FILT_CYCLES, 4, consecutive stable cycles required by the glitch filter (>=1)
- LOCK_CYCLES, 16, cycles PLL lock must stay high before system reset release (>=1)

Ports:
- clk_i  in  1  single clock; all logic rising-edge
- rst_i  in  1  synchronous, active-high reset
- pll_locked_i  in  1  asynchronous PLL/MMCM lock flag
- rst_sys_no  out  1  active-low system reset to SoC core
- pad_in_i  in  NUM_PADS  raw pad input values (asynchronous)
- pad_out_o  out  NUM_PADS  pad output drive values
- pad_oe_o  out  NUM_PADS  pad output enables (1 = drive, 0 = Hi-Z)
- core_in_o  out  NUM_PADS  synchronised/filtered inputs to core
- core_out_i  in  NUM_PADS  core output values
- core_oe_i  in  NUM_PADS  core output enables
- filt_en_i  in  NUM_PADS  per-channel glitch filter enable

Behaviour:
- Reset (rst_i=1 at edge):
  - all flops to 0
  - rst_sys_no=0; pad_out_o=0; pad_oe_o=0; core_in_o=0
  - filter counters=0; lock counter=0; FSM=HOLD
- Lock sync: 2-flop synchroniser on pll_locked_i → lock_s.
- Reset FSM (state register; rst_sys_no = (state==RUN), glitch-free, no combinational path from inputs):
  - HOLD: next cycle → WAIT_LOCK unconditionally.
  - WAIT_LOCK: lock_s=1 → COUNT, lock counter cleared to 0.
  - COUNT: lock_s=0 → WAIT_LOCK. Otherwise counter increments; when counter==LOCK_CYCLES-1 → RUN.
  - RUN: lock_s=0 → WAIT_LOCK, so rst_sys_no falls on the next edge.
- Release latency: lock_s high continuously ⇒ RUN entered exactly LOCK_CYCLES edges after entering COUNT.
- Lock counter width: $clog2(LOCK_CYCLES+1); it never wraps.
- Input path, per channel i:
  - pad_in_i[i] → 2-flop synchroniser → s[i].
  - Filter counter fc[i], width $clog2(FILT_CYCLES+1).
  - Effective threshold T = filt_en_i[i] ? FILT_CYCLES : 1.
  - If s[i]==core_in_o[i]: fc[i]←0.
  - Else if fc[i]==T-1: core_in_o[i]←s[i], fc[i]←0.
  - Else: fc[i]←fc[i]+1.
  - Latency from a stable pad change: unfiltered, core_in_o updates on the 3rd edge; filtered, on edge 2+FILT_CYCLES.
  - A pulse shorter than FILT_CYCLES sync-domain cycles is fully rejected.
  - filt_en_i change mid-count: the new threshold applies immediately. If fc[i]>=T-1, the update happens on that edge.
  - The input path runs regardless of FSM state (not gated by rst_sys_no).
- Output path, registered, 1-cycle latency:
  - pad_oe_o[i] ← (state==RUN) & core_oe_i[i]
  - pad_out_o[i] ← (state==RUN) & core_out_i[i]
  - pad_oe_o therefore goes 0 one edge after the FSM leaves RUN, and becomes valid one edge after entering RUN.
- Board-level tristate (pad = oe ? out : Z) is done by the wrapper's IOBUF, not in this block.
- Simultaneous events:
  - rst_i dominates everything.
  - A lock drop in the same cycle as counter==LOCK_CYCLES-1 → WAIT_LOCK (no release).

Optional Feature:
- Macro: FPGA_PAD_RING_LOOPBACK_EN.
- When defined, adds input port loopback_i (1 bit).
  - While loopback_i=1: pad_oe_o and pad_out_o are forced to 0 at the next edge.
  - core_in_o[i] ← core_out_i[i] registered (1-cycle latency), bypassing synchroniser and filter; fc cleared.
  - Synchroniser flops keep sampling.
  - On loopback_i deassertion, normal filtering resumes from the current core_in_o value.
- When undefined: no loopback_i port; behaviour exactly as in Behaviour.

Test Plan:
1. Reset release: rst_i 1→0, pll_locked_i=1 constant, LOCK_CYCLES=16 → rst_sys_no stays 0 through HOLD, 2-cycle sync and WAIT_LOCK, then rises exactly 16 edges after COUNT entry; pad_oe_o=0 throughout.
2. Lock glitch: lock drops for 1 cycle at count 10 → FSM back to WAIT_LOCK, full 16 recounted. Lock drop in RUN → rst_sys_no=0 within 3 edges of pll_locked_i fall, pad_oe_o=0 one edge later.
3. Filter reject/accept, FILT_CYCLES=4, filt_en_i[0]=1: 3-cycle high pulse on pad_in_i[0] → core_in_o[0] stays 0. 4-cycle stable high → core_in_o[0]=1 on edge 6 after pad change.
4. Unfiltered latency: filt_en_i[1]=0, pad_in_i[1] 0→1 → core_in_o[1]=1 on 3rd edge. A 1-cycle pulse propagates as a 1-cycle pulse.
5. Output gating: in RUN, core_oe_i=8'hA5, core_out_i=8'h3C → next edge pad_oe_o=8'hA5, pad_out_o=8'h3C. Assert rst_i mid-operation → all outputs 0 at next edge.
6. Loopback (macro defined): loopback_i=1, core_out_i=8'h5A → pad_oe_o=0 and core_in_o=8'h5A one edge later. Clear loopback with pads at 0 → core_in_o returns to 0 after filter latency.
